// File: rtl/vector_pkg.sv
// Shared state encodings and fade-mode constants for the vector framebuffer scheduler.
package vector_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STEP_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 5'd0,
    S_PREP     = 5'd1,
    S_CLEAR    = 5'd2,
    S_SW_ADDR  = 5'd3,
    S_SW_WAIT  = 5'd4,
    S_SW_WRITE = 5'd5,
    S_DONE     = 5'd6,
    S_DRAW     = 5'd7
  } state_t;

  localparam logic [MODE_W-1:0] FADE_NONE  = 2'd0;
  localparam logic [MODE_W-1:0] FADE_CLEAR = 2'd1;
  localparam logic [MODE_W-1:0] FADE_HALVE = 2'd2;
  localparam logic [MODE_W-1:0] FADE_SUB   = 2'd3;

endpackage

// File: rtl/vector_fade_alu.sv
// Combinational per-byte fade: clear, halve or saturating subtract of a framebuffer byte.
module vector_fade_alu
  import vector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [MODE_W-1:0]     mode,
  input  logic [STEP_W-1:0]     step,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned CW = (DATA_WIDTH > STEP_W) ? DATA_WIDTH : STEP_W;

  logic [CW-1:0] q_w;
  logic [CW-1:0] step_w;
  logic [CW-1:0] diff;

  always_comb begin
    q_w    = CW'(q);
    step_w = CW'(step);
    diff   = q_w - step_w;
    data   = q;
    case (mode)
      FADE_CLEAR: data = '0;
      FADE_HALVE: data = q >> 1;
      // Saturate at zero rather than wrapping.
      FADE_SUB:   data = (q_w > step_w) ? DATA_WIDTH'(diff) : '0;
      default:    data = q;
    endcase
  end

endmodule

// File: rtl/vector_fb_scheduler.sv
// Framebuffer port-B owner: per-vblank fade sweep followed by granting renderer pixel writes.
module vector_fb_scheduler
  import vector_pkg::*;
#(
  parameter int unsigned FB_ADDR_WIDTH = 16,
  parameter int unsigned FB_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vblank,
  input  logic [MODE_W-1:0]        fade_mode,
  input  logic [STEP_W-1:0]        fade_step,
  input  logic                     overrun_clr,
  input  logic                     draw_req,
  input  logic [FB_ADDR_WIDTH-1:0] draw_addr,
  input  logic [FB_DATA_WIDTH-1:0] draw_data,
  output logic                     draw_ready,
  output logic                     draw_start,
  output logic                     sweep_busy,
  output logic                     frame_overrun,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr,
  output logic                     fb_wr,
  output logic [FB_DATA_WIDTH-1:0] fb_data,
  input  logic [FB_DATA_WIDTH-1:0] fb_q
);

  state_t                   state;
  logic                     vblank_last;
  logic                     vb_edge;
  logic [FB_ADDR_WIDTH-1:0] ptr;
  logic                     ptr_last;
  logic [MODE_W-1:0]        mode_q;
  logic [STEP_W-1:0]        step_q;
  logic [FB_DATA_WIDTH-1:0] fade_data;

  assign vb_edge    = vblank && !vblank_last;
  assign ptr_last   = &ptr;
  assign draw_ready = (state == S_DRAW);

  vector_fade_alu #(
    .DATA_WIDTH(FB_DATA_WIDTH)
  ) u_fade_alu (
    .mode (mode_q),
    .step (step_q),
    .q    (fb_q),
    .data (fade_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      vblank_last   <= 1'b1;
      ptr           <= '0;
      mode_q        <= FADE_NONE;
      step_q        <= '0;
      fb_addr       <= '0;
      fb_wr         <= 1'b0;
      fb_data       <= '0;
      draw_start    <= 1'b0;
      sweep_busy    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      vblank_last <= vblank;
      draw_start  <= 1'b0;

      // An edge arriving while a sweep is still running is flagged, not acted on.
      if (vb_edge && (state != S_IDLE) && (state != S_DRAW)) begin
        frame_overrun <= 1'b1;
      end else if (overrun_clr) begin
        frame_overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          fb_wr <= 1'b0;
          if (vb_edge) begin
            state      <= S_PREP;
            sweep_busy <= 1'b1;
          end
        end

        S_PREP: begin
          fb_wr  <= 1'b0;
          mode_q <= fade_mode;
          step_q <= fade_step;
          ptr    <= '0;
          case (fade_mode)
            FADE_NONE:  state <= S_DONE;
            FADE_CLEAR: state <= S_CLEAR;
            default:    state <= S_SW_ADDR;
          endcase
        end

        S_CLEAR: begin
          fb_addr <= ptr;
          fb_data <= '0;
          fb_wr   <= 1'b1;
          if (ptr_last) begin
            state <= S_DONE;
          end else begin
            ptr <= ptr + FB_ADDR_WIDTH'(1);
          end
        end

        S_SW_ADDR: begin
          fb_addr <= ptr;
          fb_wr   <= 1'b0;
          state   <= S_SW_WAIT;
        end

        // Registered RAM output needs a second cycle after the address change.
        S_SW_WAIT: begin
          state <= S_SW_WRITE;
        end

        S_SW_WRITE: begin
          fb_data <= fade_data;
          fb_wr   <= 1'b1;
          if (ptr_last) begin
            state <= S_DONE;
          end else begin
            ptr   <= ptr + FB_ADDR_WIDTH'(1);
            state <= S_SW_ADDR;
          end
        end

        S_DONE: begin
          draw_start <= 1'b1;
          fb_wr      <= 1'b0;
          sweep_busy <= 1'b0;
          state      <= S_DRAW;
        end

        S_DRAW: begin
          if (draw_req) begin
            fb_addr <= draw_addr;
            fb_data <= draw_data;
            fb_wr   <= 1'b1;
          end else begin
            fb_wr <= 1'b0;
          end
          if (vb_edge) begin
            state      <= S_PREP;
            sweep_busy <= 1'b1;
          end
        end

        default: begin
          fb_wr <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_fb_scheduler.sv
// Directed bench for vector_fb_scheduler with a 16-byte registered-output framebuffer model.
module tb_vector_fb_scheduler;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 16;

  logic          clk;
  logic          reset;
  logic          vblank;
  logic [1:0]    fade_mode;
  logic [7:0]    fade_step;
  logic          overrun_clr;
  logic          draw_req;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_data;
  logic          draw_ready;
  logic          draw_start;
  logic          sweep_busy;
  logic          frame_overrun;
  logic [AW-1:0] fb_addr;
  logic          fb_wr;
  logic [DW-1:0] fb_data;
  logic [DW-1:0] fb_q;

  logic [DW-1:0] mem      [N];
  logic [DW-1:0] init_mem [N];
  logic          preload;

  int checks = 0;
  int errors = 0;

  vector_fb_scheduler #(
    .FB_ADDR_WIDTH(AW),
    .FB_DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vblank        (vblank),
    .fade_mode     (fade_mode),
    .fade_step     (fade_step),
    .overrun_clr   (overrun_clr),
    .draw_req      (draw_req),
    .draw_addr     (draw_addr),
    .draw_data     (draw_data),
    .draw_ready    (draw_ready),
    .draw_start    (draw_start),
    .sweep_busy    (sweep_busy),
    .frame_overrun (frame_overrun),
    .fb_addr       (fb_addr),
    .fb_wr         (fb_wr),
    .fb_data       (fb_data),
    .fb_q          (fb_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer port B: write-first-not, registered read data.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < N; a++) mem[a] <= init_mem[a];
    end else if (fb_wr) begin
      mem[fb_addr] <= fb_data;
    end
    fb_q <= mem[fb_addr];
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] step;
    logic [7:0] pre_e;
    logic [7:0] pre_o;
    logic [7:0] exp_e;
    logic [7:0] exp_o;
    int         exp_wr;
    int         exp_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_preload(input logic [7:0] ev, input logic [7:0] od);
    @(negedge clk);
    for (int a = 0; a < N; a++) init_mem[a] = (a % 2 == 1) ? od : ev;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Raise vblank, then observe the sweep until draw_start; optional second edge mid-sweep.
  task automatic run_sweep(input logic [1:0] mode, input logic [7:0] step,
                           input bit mid_edge, input bit clr_same,
                           output int busy, output int nwr, output int addr_err,
                           output int ds_seen);
    busy = 0; nwr = 0; addr_err = 0; ds_seen = 0;
    @(negedge clk);
    fade_mode = mode;
    fade_step = step;
    vblank    = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sweep_busy) busy++;
      if (fb_wr) begin
        if (int'(fb_addr) != (nwr % N)) addr_err++;
        nwr++;
      end
      if (draw_start) begin
        ds_seen = 1;
        break;
      end
      if (c == 1) begin
        vblank    = 1'b0;
        fade_mode = ~mode;
        fade_step = ~step;
      end
      if (mid_edge && c == 6) begin
        vblank      = 1'b1;
        overrun_clr = clr_same;
      end
      if (mid_edge && c == 7) begin
        vblank      = 1'b0;
        overrun_clr = 1'b0;
      end
    end
    vblank      = 1'b0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy, nwr, aerr, ds, bad, found;

    vecs[0] = '{2'd1, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 16, 18};
    vecs[1] = '{2'd2, 8'h00, 8'h81, 8'h81, 8'h40, 8'h40, 16, 50};
    vecs[2] = '{2'd3, 8'h10, 8'h05, 8'h20, 8'h00, 8'h10, 16, 50};
    vecs[3] = '{2'd0, 8'h00, 8'h37, 8'hC8, 8'h37, 8'hC8,  0,  2};
    vecs[4] = '{2'd2, 8'h00, 8'h01, 8'hFE, 8'h00, 8'h7F, 16, 50};
    vecs[5] = '{2'd3, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 16, 50};
    vecs[6] = '{2'd3, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 16, 50};
    vecs[7] = '{2'd3, 8'h10, 8'h10, 8'h11, 8'h00, 8'h01, 16, 50};

    reset = 1'b1; vblank = 1'b1; fade_mode = 2'd0; fade_step = 8'h00;
    overrun_clr = 1'b0; draw_req = 1'b0; draw_addr = '0; draw_data = '0;
    preload = 1'b0;
    for (int a = 0; a < N; a++) init_mem[a] = 8'h00;

    // Reset values, and vblank held high through release is not an edge.
    repeat (3) @(negedge clk);
    chk("rst_fb_wr", fb_wr, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_draw_start", draw_start, 0);
    chk("rst_sweep_busy", sweep_busy, 0);
    chk("rst_overrun", frame_overrun, 0);
    chk("rst_draw_ready", draw_ready, 0);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (sweep_busy || fb_wr || draw_start) bad++;
    end
    chk("rst_vblank_high_no_sweep", bad, 0);
    vblank = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_preload(vecs[i].pre_e, vecs[i].pre_o);
      run_sweep(vecs[i].mode, vecs[i].step, 1'b0, 1'b0, busy, nwr, aerr, ds);
      chk($sformatf("v%0d_draw_start", i), ds, 1);
      chk($sformatf("v%0d_busy_cycles", i), busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
      chk($sformatf("v%0d_addr_order", i), aerr, 0);
      @(negedge clk);
      chk($sformatf("v%0d_start_pulse", i), draw_start, 0);
      chk($sformatf("v%0d_draw_ready", i), draw_ready, 1);
      for (int a = 0; a < N; a++)
        chk($sformatf("v%0d_mem%0d", i, a), mem[a],
            (a % 2 == 1) ? vecs[i].exp_o : vecs[i].exp_e);
    end

    // Back-to-back draws, with a vblank edge on the last accepted transfer.
    fade_mode = 2'd0;
    chk("draw_ready_pre", draw_ready, 1);
    draw_req = 1'b1; draw_addr = 4'd3; draw_data = 8'hA3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("draw%0d_wr", k), fb_wr, 1);
      chk($sformatf("draw%0d_addr", k), fb_addr, 3 + k);
      chk($sformatf("draw%0d_data", k), fb_data, 8'hA3 + k);
      if (k < 3) begin
        draw_addr = AW'(4 + k);
        draw_data = DW'(8'hA4 + k);
      end
      if (k == 2) vblank = 1'b1;
    end
    chk("draw_edge_ready_low", draw_ready, 0);
    chk("draw_edge_busy", sweep_busy, 1);
    draw_req = 1'b0;
    vblank = 1'b0;
    ds = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (draw_start) begin ds = 1; break; end
    end
    chk("draw_edge_sweep_done", ds, 1);
    chk("draw_edge_mem6", mem[6], 8'hA6);

    // Overrun: second edge mid-sweep flags but does not disturb the sweep.
    do_preload(8'hFF, 8'hFF);
    run_sweep(2'd1, 8'h00, 1'b1, 1'b0, busy, nwr, aerr, ds);
    chk("ovr_done", ds, 1);
    chk("ovr_writes", nwr, 16);
    chk("ovr_busy_cycles", busy, 18);
    chk("ovr_addr_order", aerr, 0);
    chk("ovr_flag", frame_overrun, 1);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("ovr_cleared", frame_overrun, 0);
    run_sweep(2'd1, 8'h00, 1'b1, 1'b1, busy, nwr, aerr, ds);
    chk("ovr_set_wins", frame_overrun, 1);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("ovr_cleared2", frame_overrun, 0);

    // Reset while clearing with ptr at 7; vblank stays high through release.
    do_preload(8'hFF, 8'hFF);
    @(negedge clk);
    fade_mode = 2'd1;
    vblank = 1'b1;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fb_wr && fb_addr == 4'd6) begin
        found = 1;
        reset = 1'b1;
        break;
      end
    end
    chk("rstmid_reached_ptr7", found, 1);
    @(negedge clk);
    chk("rstmid_fb_wr", fb_wr, 0);
    chk("rstmid_busy", sweep_busy, 0);
    chk("rstmid_ready", draw_ready, 0);
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (sweep_busy || fb_wr || draw_start) bad++;
    end
    chk("rstmid_no_sweep", bad, 0);
    chk("rstmid_mem6", mem[6], 8'h00);
    chk("rstmid_mem7", mem[7], 8'hFF);
    vblank = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_fb_scheduler.md
Name: vector_fb_scheduler

Overview:
- Owns the write/read port B of the 256x256 vector framebuffer.
- At each vblank rising edge it runs a framebuffer sweep: clear, halve (phosphor decay) or saturating subtract. It then pulses draw_start so the line renderer begins its pass.
- Between sweeps it grants pixel writes from the line renderer through a valid/ready handshake.
- It sits between the vector line renderer and the framebuffer dpram_dc.

Parameters:
- FB_ADDR_WIDTH, 16, framebuffer address width. The sweep covers 2^FB_ADDR_WIDTH bytes. Benches use 4.
- FB_DATA_WIDTH, 8, framebuffer byte width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- vblank  in  1  vertical blank level from the video timing.
- fade_mode  in  2  0 none, 1 clear, 2 halve, 3 subtract.
- fade_step  in  8  decrement used by mode 3.
- overrun_clr  in  1  clears frame_overrun.
- draw_req  in  1  renderer has a pixel write pending.
- draw_addr  in  FB_ADDR_WIDTH  pixel address {y,x}.
- draw_data  in  FB_DATA_WIDTH  pixel value.
- draw_ready  out  1  combinational; a transfer occurs when draw_req && draw_ready.
- draw_start  out  1  one-cycle pulse: sweep done, renderer may begin.
- sweep_busy  out  1  high while the sweep is in progress.
- frame_overrun  out  1  sticky flag.
- fb_addr  out  FB_ADDR_WIDTH  registered port-B address.
- fb_wr  out  1  registered port-B write enable.
- fb_data  out  FB_DATA_WIDTH  registered port-B write data.
- fb_q  in  FB_DATA_WIDTH  port-B read data. Valid in the second cycle after fb_addr changes (registered RAM output).

Behaviour:
- Reset values: state S_IDLE; fb_addr, fb_wr, fb_data, draw_start, sweep_busy and frame_overrun all 0. vblank_last resets to 1, so a vblank that is already high at reset release does not count as an edge.
- vb_edge is vblank && !vblank_last.
- State machine:
  - S_IDLE: draw_ready=0. On vb_edge go to S_PREP.
  - S_PREP: latch fade_mode and fade_step; ptr<=0. Next state: mode 0 -> S_DONE, 1 -> S_CLEAR, 2 or 3 -> S_SW_ADDR. Any draw accepted in the previous cycle drives fb_wr during this cycle.
  - S_CLEAR: fb_addr<=ptr, fb_data<=0, fb_wr<=1, ptr++. Go to S_DONE once ptr reaches its maximum. Cost: 2^W cycles.
  - S_SW_ADDR: fb_addr<=ptr, fb_wr<=0.
  - S_SW_WAIT: wait one cycle for read data.
  - S_SW_WRITE: fb_data<=fade(fb_q), fb_wr<=1, fb_addr unchanged. If ptr is at maximum go to S_DONE; otherwise ptr++ and go to S_SW_ADDR. Cost: 3 cycles per address.
  - S_DONE: draw_start<=1 for one cycle, fb_wr<=0, then go to S_DRAW.
  - S_DRAW: draw_ready=1. On an accepted transfer, next cycle fb_addr=draw_addr, fb_data=draw_data, fb_wr=1. Otherwise fb_wr=0. This gives one write per cycle back-to-back. On vb_edge go to S_PREP; a transfer accepted in the same cycle still completes during S_PREP.
- fade function: mode 2 gives q>>1. Mode 3 gives q>step ? q-step : 0 (saturating, never wraps).
- sweep_busy is registered high in S_PREP, S_CLEAR, S_SW_ADDR, S_SW_WAIT and S_SW_WRITE.
- draw_ready is 0 in every state except S_DRAW. draw_req must hold addr/data stable until accepted.
- Overrun: a vb_edge in any state other than S_IDLE or S_DRAW sets frame_overrun and is otherwise ignored; the sweep continues. When overrun_clr and a new overrun occur in the same cycle, set wins.
- The ptr counter never wraps; completion is detected at the all-ones address.
- Reset mid-sweep aborts immediately: fb_wr is 0 from the next cycle, the framebuffer is left partially swept, and the block returns to S_IDLE.
- fade_mode changes during a sweep have no effect until the next S_PREP.

Decomposition:
- vector_pkg holds the state encodings (5-bit, matching the existing vector state width) and the constants FADE_NONE/FADE_CLEAR/FADE_HALVE/FADE_SUB.
- Sub-module vector_fade_alu: purely combinational (mode, step, q) -> data. Instantiated once; unit-testable in isolation.

Test Plan (FB_ADDR_WIDTH=4):
- Clear: preload all 16 bytes 0xFF, fade_mode=1, pulse vblank -> 16 consecutive fb_wr cycles with data 0x00 at addresses 0..15, then a draw_start pulse on the cycle after the last write; sweep_busy falls at the same time.
- Halve: preload 0x81 everywhere, mode 2 -> each address rewritten with 0x40; 48 cycles from S_SW_ADDR entry to S_DONE.
- Subtract saturation: bytes 0x05 and 0x20, mode 3, step 0x10 -> results 0x00 and 0x10; 0x05 never wraps to 0xF5.
- Draw throughput and edge: hold draw_req high for 4 cycles with addresses 3,4,5,6 in S_DRAW -> 4 back-to-back fb_wr. Then raise vblank on the cycle address 6 is accepted -> address 6 is written, draw_ready drops, and the sweep starts the next cycle.
- Overrun: pulse vblank again mid-sweep -> frame_overrun=1 and the sweep still finishes all 16 addresses. overrun_clr -> flag returns to 0.
- Reset mid-sweep at ptr=7 -> fb_wr=0 the next cycle and state S_IDLE. Holding vblank high through reset release produces no sweep.
